// File: rtl/sync_fifo_param_pkg.sv
// Shared FIFO types and defaults: status flag bundle, ack encodings, default geometry.
package sync_fifo_param_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 8;

  localparam logic SUCCESS = 1'b1;
  localparam logic FAILED  = 1'b0;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_param_ram.sv
// FIFO storage: DEPTH x DATA_W register array, synchronous write, asynchronous read.
module sync_fifo_param_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately have no reset; occupancy is tracked by the controller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with programmable almost-flags and optional first-word-fall-through.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W = FIFO_WIDTH,
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned FWFT   = 0,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [CNT_W-1:0]  af_thresh,
  input  logic [CNT_W-1:0]  ae_thresh,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow,
  output logic              full,
  output logic              empty,
  output logic              almostfull,
  output logic              almostempty,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_acc;
  logic              wr_acc;
  fifo_status_t      status;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    status             = '0;
    status.full        = (count == CNT_W'(DEPTH));
    status.empty       = (count == '0);
    status.almostfull  = (count >= af_thresh);
    status.almostempty = (count <= ae_thresh);
  end

  assign full        = status.full;
  assign empty       = status.empty;
  assign almostfull  = status.almostfull;
  assign almostempty = status.almostempty;

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = rd_en && !status.empty;
  assign wr_acc = wr_en && (!status.full || rd_acc);

  sync_fifo_param_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= FAILED;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      count <= count + CNT_W'(1);
      else if (rd_acc && !wr_acc) count <= count - CNT_W'(1);
      wr_ack    <= wr_acc ? SUCCESS : FAILED;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = status.empty ? '0 : rd_data;
      assign rd_valid = !status.empty;
    end else begin : g_std
      // Registered read: data_out holds the last popped word between reads.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) data_out <= rd_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: depth-8 standard, depth-5 standard (wrap) and depth-8 FWFT instances.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // depth 8, standard read
  logic [15:0] d_a = '0, q_a;
  logic        w_a = 0, r_a = 0;
  logic [3:0]  af_a = 4'd6, ae_a = 4'd2, cnt_a;
  logic        rv_a, ack_a, ov_a, un_a, fu_a, em_a, afl_a, ael_a;

  // depth 5, standard read
  logic [15:0] d_b = '0, q_b;
  logic        w_b = 0, r_b = 0;
  logic [2:0]  af_b = 3'd4, ae_b = 3'd1, cnt_b;
  logic        rv_b, ack_b, ov_b, un_b, fu_b, em_b, afl_b, ael_b;

  // depth 8, first-word-fall-through
  logic [15:0] d_f = '0, q_f;
  logic        w_f = 0, r_f = 0;
  logic [3:0]  af_f = 4'd6, ae_f = 4'd2, cnt_f;
  logic        rv_f, ack_f, ov_f, un_f, fu_f, em_f, afl_f, ael_f;

  sync_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(0)) u_dut_a (
    .clk(clk), .rst(rst), .data_in(d_a), .wr_en(w_a), .rd_en(r_a),
    .af_thresh(af_a), .ae_thresh(ae_a), .data_out(q_a), .rd_valid(rv_a),
    .wr_ack(ack_a), .overflow(ov_a), .underflow(un_a), .full(fu_a), .empty(em_a),
    .almostfull(afl_a), .almostempty(ael_a), .count(cnt_a));

  sync_fifo_param #(.DATA_W(16), .DEPTH(5), .FWFT(0)) u_dut_b (
    .clk(clk), .rst(rst), .data_in(d_b), .wr_en(w_b), .rd_en(r_b),
    .af_thresh(af_b), .ae_thresh(ae_b), .data_out(q_b), .rd_valid(rv_b),
    .wr_ack(ack_b), .overflow(ov_b), .underflow(un_b), .full(fu_b), .empty(em_b),
    .almostfull(afl_b), .almostempty(ael_b), .count(cnt_b));

  sync_fifo_param #(.DATA_W(16), .DEPTH(8), .FWFT(1)) u_dut_f (
    .clk(clk), .rst(rst), .data_in(d_f), .wr_en(w_f), .rd_en(r_f),
    .af_thresh(af_f), .ae_thresh(ae_f), .data_out(q_f), .rd_valid(rv_f),
    .wr_ack(ack_f), .overflow(ov_f), .underflow(un_f), .full(fu_f), .empty(em_f),
    .almostfull(afl_f), .almostempty(ael_f), .count(cnt_f));

  int n_total = 0;
  int n_pass  = 0;

  int q_model[$];
  int nxt, got, k, exp_d;
  bit racc, wacc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    // reset state
    step(); step();
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_empty", 32'(em_a), 1);
    chk("rst_full", 32'(fu_a), 0);
    chk("rst_rd_valid", 32'(rv_a), 0);
    chk("rst_data_out", 32'(q_a), 0);
    chk("rst_wr_ack", 32'(ack_a), 0);
    chk("rst_flags", {29'd0, ov_a, un_a, 1'b0}, 0);
    rst = 1'b0;

    // fill to full, then one overflow
    for (int i = 0; i < 8; i++) begin
      w_a = 1; d_a = 16'hA000 + 16'(i);
      step();
      chk("fill_ack", 32'(ack_a), 1);
      chk("fill_count", 32'(cnt_a), 32'(i + 1));
    end
    chk("fill_full", 32'(fu_a), 1);
    d_a = 16'hA008;
    step();
    chk("ovf_overflow", 32'(ov_a), 1);
    chk("ovf_ack", 32'(ack_a), 0);
    chk("ovf_count", 32'(cnt_a), 8);
    w_a = 0;

    // drain with registered read, then one underflow
    r_a = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_valid", 32'(rv_a), 1);
      chk("drain_data", 32'(q_a), 32'h0000A000 + 32'(i));
      chk("drain_count", 32'(cnt_a), 32'(7 - i));
    end
    step();
    chk("unf_underflow", 32'(un_a), 1);
    chk("unf_valid", 32'(rv_a), 0);
    chk("unf_hold", 32'(q_a), 32'h0000A007);
    chk("unf_empty", 32'(em_a), 1);
    r_a = 0;

    // simultaneous read+write at full and at empty
    w_a = 1;
    for (int i = 0; i < 8; i++) begin
      d_a = 16'hD000 + 16'(i);
      step();
    end
    chk("sim_prefull", 32'(cnt_a), 8);
    r_a = 1; d_a = 16'hB000;
    step();
    chk("simf_ack", 32'(ack_a), 1);
    chk("simf_ovf", 32'(ov_a), 0);
    chk("simf_count", 32'(cnt_a), 8);
    chk("simf_data", 32'(q_a), 32'h0000D000);
    w_a = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("simd_data", 32'(q_a), 32'h0000D000 + 32'(i));
    end
    step();
    chk("simd_last", 32'(q_a), 32'h0000B000);
    chk("simd_empty", 32'(em_a), 1);
    w_a = 1; d_a = 16'hC000;
    step();
    chk("sime_ack", 32'(ack_a), 1);
    chk("sime_unf", 32'(un_a), 1);
    chk("sime_count", 32'(cnt_a), 1);
    chk("sime_valid", 32'(rv_a), 0);
    w_a = 0;
    step();
    chk("sime_pop", 32'(q_a), 32'h0000C000);
    chk("sime_empty", 32'(em_a), 1);
    r_a = 0;

    // thresholds af=6 ae=2
    w_a = 1; d_a = 16'hE000;
    step(); step();
    chk("th2_ae", 32'(ael_a), 1);
    chk("th2_af", 32'(afl_a), 0);
    step();
    chk("th3_ae", 32'(ael_a), 0);
    chk("th3_af", 32'(afl_a), 0);
    step(); step();
    chk("th5_ae", 32'(ael_a), 0);
    chk("th5_af", 32'(afl_a), 0);
    step();
    chk("th6_ae", 32'(ael_a), 0);
    chk("th6_af", 32'(afl_a), 1);
    w_a = 0; r_a = 1;
    step();
    r_a = 0;
    chk("th_cnt5", 32'(cnt_a), 5);
    chk("th5b_af", 32'(afl_a), 0);
    af_a = 4'd4;
    #1;
    chk("th_af4_now", 32'(afl_a), 1);
    af_a = 4'd0;
    #1;
    chk("th_af0", 32'(afl_a), 1);
    ae_a = 4'd8;
    #1;
    chk("th_ae8", 32'(ael_a), 1);
    ae_a = 4'd4;
    #1;
    chk("th_ae4", 32'(ael_a), 0);

    // depth-5 wrap: interleaved traffic against a queue model
    nxt = 1; got = 0; k = 0;
    while (got < 20 && k < 200) begin
      w_b = (nxt <= 20) && (k % 4 != 3);
      r_b = ((k >= 6) && (k % 2 == 0)) || (nxt > 20);
      d_b = 16'(nxt);
      racc = r_b && (q_model.size() > 0);
      wacc = w_b && ((q_model.size() < 5) || racc);
      if (racc) exp_d = q_model.pop_front();
      if (wacc) begin
        q_model.push_back(nxt);
        nxt++;
      end
      step();
      chk("wrap_count", 32'(cnt_b), 32'(q_model.size()));
      chk("wrap_full", 32'(fu_b), 32'(q_model.size() == 5));
      chk("wrap_empty", 32'(em_b), 32'(q_model.size() == 0));
      chk("wrap_valid", 32'(rv_b), 32'(racc));
      chk("wrap_ovf", 32'(ov_b), 32'(w_b && !wacc));
      if (racc) begin
        chk("wrap_data", 32'(q_b), 32'(exp_d));
        got++;
      end
      k++;
    end
    chk("wrap_all_read", 32'(got), 20);
    w_b = 0; r_b = 1;
    step();
    chk("wrap_unf", 32'(un_b), 1);
    r_b = 0;

    // FWFT head visibility, pop, and asynchronous reset mid-cycle
    chk("fw_idle_valid", 32'(rv_f), 0);
    chk("fw_idle_data", 32'(q_f), 0);
    w_f = 1; d_f = 16'h1234;
    step();
    chk("fw_head", 32'(q_f), 32'h00001234);
    chk("fw_valid", 32'(rv_f), 1);
    d_f = 16'h5678;
    step();
    chk("fw_cnt2", 32'(cnt_f), 2);
    chk("fw_head_keep", 32'(q_f), 32'h00001234);
    w_f = 0; r_f = 1;
    step();
    r_f = 0;
    chk("fw_pop", 32'(q_f), 32'h00005678);
    chk("fw_cnt1", 32'(cnt_f), 1);
    w_f = 1; d_f = 16'h9ABC;
    #3 rst = 1'b1;
    #1;
    chk("fw_rst_count", 32'(cnt_f), 0);
    chk("fw_rst_empty", 32'(em_f), 1);
    chk("fw_rst_data", 32'(q_f), 0);
    chk("fw_rst_valid", 32'(rv_f), 0);
    w_f = 0;
    rst = 1'b0;
    step();
    chk("fw_post_empty", 32'(em_f), 1);
    chk("fw_post_count", 32'(cnt_f), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
